// File: rtl/xort_pulse_sequencer_if.sv
// xort_pulse_sequencer_if: operand/result handshake plus the toggle lines to and from one xort cell
interface xort_pulse_sequencer_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready;
  logic [WIDTH-1:0] opa, opb;
  logic xa, xb, xclk, xout;
  logic res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic err;
  modport master(output in_valid, opa, opb, res_ready, xout, input in_ready, xa, xb, xclk, res_valid, res_data, err);
  modport slave(input in_valid, opa, opb, res_ready, xout, output in_ready, xa, xb, xclk, res_valid, res_data, err);
endinterface

// File: rtl/xort_pulse_sequencer.sv
// xort_pulse_sequencer: serialises operand pairs LSB first into an xort cell and assembles the XOR result
module xort_pulse_sequencer #(
  parameter int WIDTH = 8,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC = 3
) (
  input logic clk,
  input logic rst_n,
  xort_pulse_sequencer_if.slave bus
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2((SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC) + 1);
  typedef enum logic [2:0] {IDLE, DATA, SETUP, CLOCK, SAMPLE, DONE} state_t;
  state_t st;
  logic [WIDTH-1:0] a, b, sh, rd;
  logic [IW-1:0] i;
  logic [CW-1:0] cnt;
  logic s1, s2, s3, hit, xa, xb, xc, rv, ir, er, ev, bit_now;
  assign ev = s2 ^ s3;
  assign bit_now = hit | ev;
  assign bus.in_ready = ir;
  assign bus.xa = xa;
  assign bus.xb = xb;
  assign bus.xclk = xc;
  assign bus.res_valid = rv;
  assign bus.res_data = rd;
  assign bus.err = er;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      {a, b, sh, rd} <= '0;
      i <= '0;
      cnt <= '0;
      {s1, s2, s3, hit, xa, xb, xc, rv, er} <= '0;
      ir <= 1'b1;
    end else begin
      s1 <= bus.xout;
      s2 <= s1;
      s3 <= s2;
      // any edge outside the sample window is a stray pulse; an accept below overrides this
      if (ev && st != SAMPLE) er <= 1'b1;
      case (st)
        IDLE: if (bus.in_valid) begin
          a <= bus.opa;
          b <= bus.opb;
          sh <= '0;
          i <= '0;
          er <= 1'b0;
          ir <= 1'b0;
          st <= DATA;
        end
        DATA: begin
          xa <= xa ^ a[i];
          xb <= xb ^ b[i];
          cnt <= '0;
          st <= SETUP;
        end
        SETUP: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(SETUP_CYC - 1)) st <= CLOCK;
        end
        CLOCK: begin
          xc <= ~xc;
          hit <= 1'b0;
          cnt <= '0;
          st <= SAMPLE;
        end
        SAMPLE: begin
          if (ev) begin
            hit <= 1'b1;
            if (hit) er <= 1'b1;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(HOLD_CYC - 1)) begin
            sh <= WIDTH'({bit_now, sh} >> 1);
            i <= i + IW'(1);
            st <= i == IW'(WIDTH - 1) ? DONE : DATA;
          end
        end
        DONE: if (!rv) begin
          rv <= 1'b1;
          rd <= sh;
        end else if (bus.res_ready) begin
          rv <= 1'b0;
          ir <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_xort_pulse_sequencer.sv
// tb_xort_pulse_sequencer: drives words through the sequencer against a behavioural xort cell model
module tb_xort_pulse_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  xort_pulse_sequencer_if #(.WIDTH(8)) bus ();
  xort_pulse_sequencer #(.WIDTH(8), .SETUP_CYC(2), .HOLD_CYC(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int na = 0, nb = 0, nc = 0, ba = 0, bb = 0, bc = 0;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0, fa = 1'b0, fb = 1'b0, xo = 1'b0, stray_t = 1'b0;
  assign bus.xout = xo ^ stray_t;
  // cell: remembers which data inputs pulsed, emits an output pulse on clk if exactly one did
  always @(bus.xa or bus.xb or bus.xclk or rst_n) begin
    if (!rst_n) begin
      fa = 1'b0;
      fb = 1'b0;
      xo = 1'b0;
    end else begin
      if (bus.xa !== pa) begin fa = 1'b1; na++; end
      if (bus.xb !== pb) begin fb = 1'b1; nb++; end
      if (bus.xclk !== pc) begin
        nc++;
        if (fa ^ fb) xo = ~xo;
        fa = 1'b0;
        fb = 1'b0;
      end
    end
    pa = bus.xa;
    pb = bus.xb;
    pc = bus.xclk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opa = a;
    bus.opb = b;
    ba = na; bb = nb; bc = nc;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("busy_in_ready", bus.in_ready, 0);
    chk("err_cleared", bus.err, 0);
  endtask
  task automatic wait_res(input bit stray, output int cyc);
    cyc = 0;
    while (!bus.res_valid && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (stray && cyc == 15) stray_t = ~stray_t;
    end
  endtask
  task automatic check_word(input logic [7:0] a, input logic [7:0] b, input bit stray, input int cyc);
    chk("latency", cyc, 57);
    chk("res_data", bus.res_data, a ^ b);
    chk("err", bus.err, stray);
    chk("xclk_toggles", nc - bc, 8);
    chk("xa_toggles", na - ba, $countones(a));
    chk("xb_toggles", nb - bb, $countones(b));
  endtask
  task automatic run_word(input logic [7:0] a, input logic [7:0] b, input bit stray, input int hold);
    int cyc;
    bus.res_ready = hold == 0;
    accept(a, b);
    wait_res(stray, cyc);
    check_word(a, b, stray, cyc);
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      bus.opa = ~a;
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        chk("hold_valid", bus.res_valid, 1);
        chk("hold_data", bus.res_data, a ^ b);
        chk("hold_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      bus.res_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", bus.res_valid, 0);
    chk("post_hs_in_ready", bus.in_ready, 1);
  endtask
  initial begin
    int cyc;
    logic [7:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.opa = '0;
    bus.opb = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_xa", bus.xa, 0);
    chk("rst_xb", bus.xb, 0);
    chk("rst_xclk", bus.xclk, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_err", bus.err, 0);
    rst_n = 1'b1;
    run_word(8'hA5, 8'h0F, 1'b0, 0);
    run_word(8'hFF, 8'hFF, 1'b0, 0);
    run_word(8'h3C, 8'hC3, 1'b0, 10);
    run_word(8'h96, 8'h21, 1'b1, 0);
    run_word(8'h5A, 8'h18, 1'b0, 0);
    accept(8'h3C, 8'h5A);
    repeat (26) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    stray_t = 1'b0;
    #1;
    chk("midrst_xa", bus.xa, 0);
    chk("midrst_xb", bus.xb, 0);
    chk("midrst_xclk", bus.xclk, 0);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(8'h3C, 8'h5A, 1'b0, 0);
    bus.res_ready = 1'b1;
    accept(8'h01, 8'h00);
    wait_res(1'b0, cyc);
    check_word(8'h01, 8'h00, 1'b0, cyc);
    bus.in_valid = 1'b1;
    bus.opa = 8'hC6;
    bus.opb = 8'h6C;
    ba = na; bb = nb; bc = nc;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_hs_in_ready", bus.in_ready, 1);
    chk("b2b_hs_valid", bus.res_valid, 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_accepted", bus.in_ready, 0);
    wait_res(1'b0, cyc);
    check_word(8'hC6, 8'h6C, 1'b0, cyc);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_word(ra, rb, 1'b0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
